// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared types and constants for the core sequencing controller
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BOOT,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_CMD    = 2'd1,
        CAUSE_EBREAK = 2'd2,
        CAUSE_LIMIT  = 2'd3
    } halt_cause_e;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - program-load stream and instruction-memory write bus
interface core_seq_ctrl_if;

    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - load/boot/run/step/halt sequencing for a small core
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    core_seq_ctrl_if.slave        load_if,
    input  logic                  run_cmd,
    input  logic                  step_cmd,
    input  logic                  halt_cmd,
    input  logic                  restart_cmd,
    input  logic [31:0]           max_cycles,
    input  logic [31:0]           core_instr,
    input  logic [31:0]           core_pc,
    output logic                  core_rst,
    output logic                  core_en,
    output logic                  halted,
    output logic [1:0]            halt_cause,
    output logic [31:0]           halt_pc,
    output logic [31:0]           cycle_count
);

    localparam int BOOT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(RST_CYCLES - 1);
    localparam logic [31:0] LAST_WORD = 32'(IMEM_WORDS - 1);

    seq_state_e        state, state_next;
    halt_cause_e       cause_q, cause_now;
    logic [31:0]       word_cnt;
    logic [BOOT_W-1:0] boot_cnt;
    logic              limit_hold;
    logic              is_ebreak, limit_hit, halt_req;
    logic              cnt_clr, cnt_inc, latch_halt, set_hold;

    assign is_ebreak = (core_instr == EBREAK_INSTR);
    // After resuming from a LIMIT halt the count still equals the limit; suppress it until the count moves.
    assign limit_hit = (max_cycles != 32'd0) && (cycle_count == max_cycles) && !limit_hold;
    assign halt_req  = halt_cmd || is_ebreak || limit_hit;

    always_comb begin
        cause_now = CAUSE_NONE;
        if (halt_cmd)       cause_now = CAUSE_CMD;
        else if (is_ebreak) cause_now = CAUSE_EBREAK;
        else if (limit_hit) cause_now = CAUSE_LIMIT;
    end

    always_comb begin
        state_next         = state;
        core_rst           = 1'b0;
        core_en            = 1'b0;
        load_if.load_ready = 1'b0;
        load_if.imem_we    = 1'b0;
        load_if.imem_waddr = 32'd0;
        load_if.imem_wdata = 32'd0;
        cnt_clr            = 1'b0;
        cnt_inc            = 1'b0;
        latch_halt         = 1'b0;
        set_hold           = 1'b0;
        if (rst) begin
            core_rst = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    core_rst = 1'b1;
                    if (load_if.load_start) begin
                        state_next = ST_LOAD;
                        cnt_clr    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    core_rst           = 1'b1;
                    load_if.load_ready = 1'b1;
                    if (load_if.load_valid) begin
                        load_if.imem_we    = 1'b1;
                        load_if.imem_waddr = {word_cnt[29:0], 2'b00};
                        load_if.imem_wdata = load_if.load_data;
                        cnt_inc            = 1'b1;
                        if (load_if.load_last || word_cnt == LAST_WORD)
                            state_next = ST_BOOT;
                    end
                end
                ST_BOOT: begin
                    core_rst = 1'b1;
                    if (boot_cnt == BOOT_LAST)
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    core_en = !halt_req;
                    if (load_if.load_start) begin
                        state_next = ST_LOAD;
                        cnt_clr    = 1'b1;
                    end else if (halt_req) begin
                        state_next = ST_HALT;
                        latch_halt = 1'b1;
                    end
                end
                ST_STEP: begin
                    core_en    = !is_ebreak;
                    state_next = ST_HALT;
                end
                ST_HALT: begin
                    if (load_if.load_start) begin
                        state_next = ST_LOAD;
                        cnt_clr    = 1'b1;
                    end else if (restart_cmd) begin
                        state_next = ST_BOOT;
                    end else if (run_cmd && cause_q != CAUSE_EBREAK) begin
                        state_next = ST_RUN;
                        set_hold   = (cause_q == CAUSE_LIMIT);
                    end else if (step_cmd) begin
                        state_next = ST_STEP;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_cnt    <= 32'd0;
            boot_cnt    <= '0;
            cause_q     <= CAUSE_NONE;
            halt_pc     <= 32'd0;
            cycle_count <= 32'd0;
            limit_hold  <= 1'b0;
        end else begin
            state <= state_next;

            if (cnt_clr)      word_cnt <= 32'd0;
            else if (cnt_inc) word_cnt <= word_cnt + 32'd1;

            boot_cnt <= (state == ST_BOOT) ? boot_cnt + 1'b1 : '0;

            if (state_next == ST_BOOT && state != ST_BOOT) begin
                cycle_count <= 32'd0;
                cause_q     <= CAUSE_NONE;
                limit_hold  <= 1'b0;
            end else begin
                if (core_en && cycle_count != 32'hFFFF_FFFF)
                    cycle_count <= cycle_count + 32'd1;
                if (set_hold)     limit_hold <= 1'b1;
                else if (core_en) limit_hold <= 1'b0;
                if (latch_halt) begin
                    cause_q <= cause_now;
                    halt_pc <= core_pc;
                end
            end
        end
    end

    assign halted     = !rst && (state == ST_HALT);
    assign halt_cause = cause_q;

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, meaning the instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter RST_CYCLES, default 2, meaning the cycles core_rst is held in BOOT (minimum 1).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  the single clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_start  input  1  begin program load.
REQ-007 load_valid  input  1  load_data is valid.
REQ-008 load_data  input  32  instruction word to write.
REQ-009 load_last  input  1  current word is the final program word.
REQ-010 load_ready  output  1  controller accepts a word.
REQ-011 imem_we  output  1  instruction-memory write strobe.
REQ-012 imem_waddr  output  32  byte address (word index x4).
REQ-013 imem_wdata  output  32  write data.
REQ-014 run_cmd / step_cmd / halt_cmd / restart_cmd  input  1 each  single-cycle command pulses.
REQ-015 max_cycles  input  32  RUN cycle limit; 0 means unlimited.
REQ-016 core_instr  input  32  instruction currently fetched by the core.
REQ-017 core_pc  input  32  current core PC.
REQ-018 core_rst  output  1  reset to the core PC and register file.
REQ-019 core_en  output  1  core advance enable (gates PC, register-file and data-memory writes).
REQ-020 halted  output  1  controller is in HALT.
REQ-021 halt_cause  output  2  0 NONE, 1 CMD, 2 EBREAK, 3 LIMIT.
REQ-022 halt_pc  output  32  core_pc captured at halt.
REQ-023 cycle_count  output  32  core-enabled cycles since BOOT.

Function
REQ-024 SHALL implement states IDLE, LOAD, BOOT, RUN, STEP and HALT.
REQ-025 In IDLE: core_rst=1, core_en=0; load_start moves to LOAD and clears the word counter.
REQ-026 In LOAD, load_ready=1; a word is accepted when load_valid&&load_ready; in the accept cycle imem_we=1 (combinational, same cycle), imem_waddr=counter*4, imem_wdata=load_data; the counter then increments.
REQ-027 LOAD SHALL exit to BOOT after accepting a word with load_last=1, or after accepting word IMEM_WORDS-1 regardless of load_last (no wrap, no further writes).
REQ-028 In BOOT: core_rst=1, core_en=0 for exactly RST_CYCLES cycles, cycle_count and halt_cause cleared, then RUN.
REQ-029 In RUN: core_rst=0; core_en=1 unless a halt condition is true in that cycle; cycle_count increments each cycle with core_en=1 and saturates at 32'hFFFFFFFF.
REQ-030 Halt conditions, priority high to low: halt_cmd (CMD); core_instr==32'h00100073 (EBREAK); max_cycles!=0 && cycle_count==max_cycles (LIMIT).
REQ-031 In the cycle a halt condition is true, core_en SHALL be 0 combinationally, so the halting instruction does not execute; on the next edge the state becomes HALT, and halt_pc and halt_cause are latched.
REQ-032 In HALT: core_rst=0, core_en=0, halted=1; core state is preserved.
REQ-033 Command priority in HALT: load_start > restart_cmd > run_cmd > step_cmd. The targets are LOAD, BOOT, RUN and STEP respectively.
REQ-034 run_cmd SHALL be ignored while halt_cause=EBREAK; restart_cmd or load_start is required to leave an EBREAK halt.
REQ-035 run_cmd with halt_cause=LIMIT SHALL resume, and the limit SHALL not retrigger until cycle_count next equals max_cycles (i.e. never, unless max_cycles has been raised).
REQ-036 STEP SHALL last exactly one cycle with core_en=1 (unless EBREAK is at core_instr, in which case core_en=0), increment cycle_count, then return to HALT with halt_cause unchanged.
REQ-037 Commands other than those listed for a state SHALL be ignored; load_start SHALL be honoured in IDLE, RUN and HALT and SHALL take priority over halt conditions in RUN.

Reset
REQ-038 rst SHALL force IDLE from any state, including mid-LOAD, and clear the word counter; already-written memory words are not cleared.
REQ-039 Reset values: core_rst=1, core_en=0, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, halted=0, halt_cause=0, halt_pc=0, cycle_count=0.

Structure
REQ-040 Package core_seq_pkg SHALL hold the state enum, the halt_cause codes and the constant EBREAK_INSTR=32'h00100073.
REQ-041 The block SHALL be a single module with no sub-module; the core and instruction memory are instantiated by the top level.

Verification
REQ-042 Load 3 words with load_last on the 3rd -> imem_we pulses at addresses 0, 4, 8; BOOT holds core_rst 2 cycles; then RUN with core_en=1.
REQ-043 IMEM_WORDS=4, stream 6 words with no load_last -> exactly 4 writes (addresses 0-12), load_ready drops, BOOT entered.
REQ-044 core_instr=32'h00100073 at PC 0x10 in RUN -> core_en=0 that cycle; then halted=1, halt_cause=2, halt_pc=0x10; run_cmd ignored; restart_cmd -> BOOT.
REQ-045 max_cycles=5 -> cycle_count reaches 5, halt_cause=3; step_cmd -> one core_en cycle, cycle_count=6, back in HALT.
REQ-046 halt_cmd and EBREAK in the same cycle -> halt_cause=1; run_cmd and step_cmd together in HALT -> RUN.
REQ-047 rst asserted after 2 of 5 load words -> IDLE next cycle with all reset values; a new load_start restarts at address 0.
